// File: rtl/sdiv_param.sv
// sdiv_param: 2N-by-N divider with signed or unsigned mode, loaded over a shared N-bit bus.
// The operands arrive as three bus words: dividend high, dividend low, then divisor.
// An exact overflow and divide-by-zero check takes one cycle.
// Restoring division on the magnitudes then produces one quotient bit per cycle.
// A final cycle applies the truncating-division sign rules.
//
// state | meaning
// IDLE  | waiting for St
// LDLO  | capture low dividend word
// LDDV  | capture divisor
// CHK   | divide-by-zero / exact overflow test, form magnitudes
// DIV   | N restoring shift-subtract steps
// FIX   | apply signs, publish result
// DONE  | result held, Rdy high, St accepted as in IDLE
module sdiv_param #(
  parameter int N = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         st_i,
  input  logic         sgn_i,
  input  logic [N-1:0] dbus_i,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o,
  output logic         v_o,
  output logic         dz_o,
  output logic         rdy_o,
  output logic         busy_o
);

  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDLO = 3'd1,
    S_LDDV = 3'd2,
    S_CHK  = 3'd3,
    S_DIV  = 3'd4,
    S_FIX  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t state_q, state_d;

  // operand capture
  logic [2*N-1:0] dvd_q, dvd_d;
  logic [N-1:0]   dvs_q, dvs_d;
  logic           sgn_q, sgn_d;

  // division datapath: acc holds {partial remainder, dividend bits / quotient bits}
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   absb_q, absb_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // published results
  logic [N-1:0]   quot_q, quot_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           v_q, v_d;
  logic           dz_q, dz_d;
  logic           rdy_q, rdy_d;
  logic           busy_q, busy_d;

  // check-stage terms
  logic           a_neg, b_neg, res_neg;
  logic           div_zero, ovf, chk_fail;
  logic [2*N-1:0] abs_a;
  logic [N-1:0]   abs_b;
  logic [2*N-1:0] b_ext, lim_pos, lim_neg;

  // division step and sign fix-up terms
  logic [N:0]     top, diff;
  logic [2*N-1:0] acc_step;
  logic [N-1:0]   q_mag, r_mag, q_fix, r_fix;

  // Exact overflow test: the magnitude quotient floor(|a|/|b|) exceeds L iff |a| >= (L+1)*|b|.
  // L is 2^(N-1)-1 for a positive signed result and 2^(N-1) for a negative one.
  always_comb begin
    a_neg    = sgn_q & dvd_q[2*N-1];
    b_neg    = sgn_q & dvs_q[N-1];
    res_neg  = a_neg ^ b_neg;
    abs_a    = a_neg ? -dvd_q : dvd_q;
    abs_b    = b_neg ? -dvs_q : dvs_q;
    div_zero = (dvs_q == '0);
    b_ext    = {{N{1'b0}}, abs_b};
    lim_pos  = b_ext << (N - 1);
    lim_neg  = lim_pos + b_ext;
    if (!sgn_q) begin
      ovf = (dvd_q[2*N-1:N] >= dvs_q);
    end else if (res_neg) begin
      ovf = (abs_a >= lim_neg);
    end else begin
      ovf = (abs_a >= lim_pos);
    end
    chk_fail = div_zero | ovf;
  end

  // One restoring step: shift left, trial-subtract the divisor, keep the result if no borrow.
  // The borrow is bit N of the difference.
  always_comb begin
    top  = acc_q[2*N-1:N-1];
    diff = top - {1'b0, absb_q};
    if (!diff[N]) begin
      acc_step = {diff[N-1:0], acc_q[N-2:0], 1'b1};
    end else begin
      acc_step = {top[N-1:0], acc_q[N-2:0], 1'b0};
    end
    q_mag = acc_q[N-1:0];
    r_mag = acc_q[2*N-1:N];
    q_fix = qneg_q ? -q_mag : q_mag;
    r_fix = rneg_q ? -r_mag : r_mag;
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (st_i) state_d = S_LDLO;
      S_LDLO:         state_d = S_LDDV;
      S_LDDV:         state_d = S_CHK;
      S_CHK:          state_d = chk_fail ? S_DONE : S_DIV;
      S_DIV:          if (cnt_q == '0) state_d = S_FIX;
      S_FIX:          state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values per state
  always_comb begin
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    sgn_d  = sgn_q;
    acc_d  = acc_q;
    absb_d = absb_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    v_d    = v_q;
    dz_d   = dz_q;
    rdy_d  = rdy_q;
    busy_d = busy_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (st_i) begin
          dvd_d[2*N-1:N] = dbus_i;
          sgn_d          = sgn_i;
          rdy_d          = 1'b0;
          busy_d         = 1'b1;
          v_d            = 1'b0;
          dz_d           = 1'b0;
        end
      end
      S_LDLO: dvd_d[N-1:0] = dbus_i;
      S_LDDV: dvs_d = dbus_i;
      S_CHK: begin
        if (chk_fail) begin
          v_d    = 1'b1;
          dz_d   = div_zero;
          quot_d = '0;
          rem_d  = '0;
          rdy_d  = 1'b1;
          busy_d = 1'b0;
        end else begin
          acc_d  = abs_a;
          absb_d = abs_b;
          qneg_d = res_neg;
          rneg_d = a_neg;
          cnt_d  = CW'(N - 1);
        end
      end
      S_DIV: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CW'(1);
      end
      S_FIX: begin
        quot_d = q_fix;
        rem_d  = r_fix;
        rdy_d  = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and result registers; reset abandons any operation in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      sgn_q  <= 1'b0;
      acc_q  <= '0;
      absb_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      v_q    <= 1'b0;
      dz_q   <= 1'b0;
      rdy_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      sgn_q  <= sgn_d;
      acc_q  <= acc_d;
      absb_q <= absb_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      v_q    <= v_d;
      dz_q   <= dz_d;
      rdy_q  <= rdy_d;
      busy_q <= busy_d;
    end
  end

  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign v_o         = v_q;
  assign dz_o        = dz_q;
  assign rdy_o       = rdy_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_sdiv_param.sv
// Bench for sdiv_param: N=16 and N=32 instances, directed cases plus random operands
// checked against an arithmetic reference model.
module tb_sdiv_param;

  logic clk = 1'b0;
  logic rst;

  logic        st16, sgn16;
  logic [15:0] d16, q16, r16;
  logic        v16, dz16, rdy16, busy16;

  logic        st32, sgn32;
  logic [31:0] d32, q32, r32;
  logic        v32, dz32, rdy32, busy32;

  int checks = 0;
  int errors = 0;

  bit          sel32;
  logic [31:0] oq, orr;
  logic        ov, odz, ordy, obusy;
  logic [63:0] last_q16, last_r16, last_q32, last_r32;

  assign oq    = sel32 ? q32 : {16'h0, q16};
  assign orr   = sel32 ? r32 : {16'h0, r16};
  assign ov    = sel32 ? v32 : v16;
  assign odz   = sel32 ? dz32 : dz16;
  assign ordy  = sel32 ? rdy32 : rdy16;
  assign obusy = sel32 ? busy32 : busy16;

  sdiv_param #(.N(16)) u16 (
    .clk_i(clk), .rst_i(rst), .st_i(st16), .sgn_i(sgn16), .dbus_i(d16),
    .quotient_o(q16), .remainder_o(r16), .v_o(v16), .dz_o(dz16),
    .rdy_o(rdy16), .busy_o(busy16)
  );

  sdiv_param #(.N(32)) u32 (
    .clk_i(clk), .rst_i(rst), .st_i(st32), .sgn_i(sgn32), .dbus_i(d32),
    .quotient_o(q32), .remainder_o(r32), .v_o(v32), .dz_o(dz32),
    .rdy_o(rdy32), .busy_o(busy32)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division on the sign-extended operands, then range test.
  function automatic void model(input int n, input logic [63:0] dvd, input logic [63:0] dvs,
                                input bit sgn, output logic [63:0] q, output logic [63:0] r,
                                output bit v, output bit dz);
    longint sa, sb, sq, sr, lo, hi;
    logic [63:0] uq, ur, mask;
    mask = (64'd1 << n) - 64'd1;
    q = '0; r = '0; v = 1'b0; sq = 0; sr = 0; uq = '0; ur = '0;
    dz = (dvs == 64'd0);
    if (dz) begin
      v = 1'b1;
      return;
    end
    if (sgn) begin
      sa = longint'(dvd << (64 - 2*n)) >>> (64 - 2*n);
      sb = longint'(dvs << (64 - n)) >>> (64 - n);
      lo = -(longint'(1) << (n - 1));
      hi = (longint'(1) << (n - 1)) - 1;
      if (sb == -1) begin
        if (sa < -hi || sa > -lo) v = 1'b1;
        else sq = -sa;
      end else begin
        sq = sa / sb;
        sr = sa % sb;
        v  = (sq < lo) || (sq > hi);
      end
      uq = 64'(sq);
      ur = 64'(sr);
    end else begin
      uq = dvd / dvs;
      ur = dvd % dvs;
      v  = (uq > mask);
    end
    if (!v) begin
      q = uq & mask;
      r = ur & mask;
    end
  endfunction

  task automatic drive(input bit w32, input bit st, input bit sgn, input logic [31:0] d);
    if (w32) begin
      st32 = st; sgn32 = sgn; d32 = d;
    end else begin
      st16 = st; sgn16 = sgn; d16 = d[15:0];
    end
  endtask

  // Full three-word load, then wait for Rdy, checking latency, Busy and the result.
  task automatic op(input string tag, input bit w32, input logic [63:0] dvd, input logic [31:0] dvs,
                    input bit sgn, input logic [63:0] eq, input logic [63:0] er,
                    input bit ev, input bit edz, input bit hold_st);
    int n, lat;
    bit busy_ok;
    logic [63:0] hi, lo, mask, pq, pr;
    n    = w32 ? 32 : 16;
    mask = (64'd1 << n) - 64'd1;
    hi   = (dvd >> n) & mask;
    lo   = dvd & mask;
    pq   = w32 ? last_q32 : last_q16;
    pr   = w32 ? last_r32 : last_r16;
    sel32 = w32;
    @(negedge clk);
    drive(w32, 1'b1, sgn, hi[31:0]);
    @(negedge clk);
    chk({tag, ":start"}, {62'b0, ordy, obusy}, 64'b01);
    chk({tag, ":hold"}, {oq, orr}, {pq[31:0], pr[31:0]});
    drive(w32, hold_st, ~sgn, lo[31:0]);
    @(negedge clk);
    drive(w32, hold_st, ~sgn, dvs);
    @(negedge clk);
    drive(w32, 1'b0, 1'($urandom_range(0, 1)), $urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (!ordy && lat < 100) begin
      if (obusy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, ":lat"}, 64'(lat), 64'(ev ? 1 : n + 2));
    chk({tag, ":qr"}, {oq, orr}, {eq[31:0], er[31:0]});
    chk({tag, ":v_dz"}, {62'b0, ov, odz}, {62'b0, ev, edz});
    chk({tag, ":busy_run"}, {63'b0, busy_ok}, 64'd1);
    chk({tag, ":done"}, {62'b0, ordy, obusy}, 64'b10);
    if (w32) begin
      last_q32 = eq; last_r32 = er;
    end else begin
      last_q16 = eq; last_r16 = er;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    st16 = 1'b0; sgn16 = 1'b0; d16 = '0;
    st32 = 1'b0; sgn32 = 1'b0; d32 = '0;
    sel32 = 1'b0;
    last_q16 = '0; last_r16 = '0; last_q32 = '0; last_r32 = '0;
    repeat (3) @(negedge clk);
    chk("reset16", {q16, r16, 28'b0, v16, dz16, rdy16, busy16}, 64'd0);
    chk("reset32", {q32, r32}, 64'd0);
    chk("reset32_flags", {60'b0, v32, dz32, rdy32, busy32}, 64'd0);
    rst = 1'b0;

    // directed signed N=16 cases, back-to-back
    op("d6f",   1'b0, 64'h0000006F, 32'h0007, 1'b1, 64'h000F, 64'h0006, 1'b0, 1'b0, 1'b0);
    op("d7ff",  1'b0, 64'h07FF00BB, 32'hE005, 1'b1, 64'hBFFE, 64'h00C5, 1'b0, 1'b0, 1'b0);
    op("dff80", 1'b0, 64'hFF80030A, 32'hEFFA, 1'b1, 64'h07FC, 64'hF2F2, 1'b0, 1'b0, 1'b1);
    op("dc000", 1'b0, 64'hC0008000, 32'h8000, 1'b1, 64'h7FFF, 64'h0000, 1'b0, 1'b0, 1'b0);
    op("dc001", 1'b0, 64'hC0008001, 32'h7FFF, 1'b1, 64'h8001, 64'h8002, 1'b0, 1'b0, 1'b0);

    // asynchronous reset in the middle of DIV
    sel32 = 1'b0;
    @(negedge clk); drive(1'b0, 1'b1, 1'b1, 32'h0000);
    @(negedge clk); drive(1'b0, 1'b0, 1'b1, 32'h006F);
    @(negedge clk); drive(1'b0, 1'b0, 1'b1, 32'h0007);
    @(negedge clk);
    repeat (5) @(negedge clk);
    chk("rst_pre", {30'b0, oq[15:0], 16'b0, ordy, obusy}, {30'b0, 16'h8001, 16'b0, 2'b01});
    rst = 1'b1;
    #1;
    chk("rst_async_qr", {oq, orr}, 64'd0);
    chk("rst_async_flags", {60'b0, ov, odz, ordy, obusy}, 64'd0);
    #2;
    rst = 1'b0;
    last_q16 = '0; last_r16 = '0;
    op("post_rst", 1'b0, 64'h0000006F, 32'h0007, 1'b1, 64'h000F, 64'h0006, 1'b0, 1'b0, 1'b0);

    // overflow, divide-by-zero and mode select
    op("ovf",   1'b0, 64'h3FFF8000, 32'h7FFF, 1'b1, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    op("dz",    1'b0, 64'hFFFFFFFF, 32'h0000, 1'b1, 64'h0, 64'h0, 1'b1, 1'b1, 1'b0);
    op("mode_u", 1'b0, 64'h00010000, 32'h0002, 1'b0, 64'h8000, 64'h0, 1'b0, 1'b0, 1'b0);
    op("mode_s", 1'b0, 64'h00010000, 32'h0002, 1'b1, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);

    // N=32
    op("w32", 1'b1, 64'hFFFFFFFF_FFFFFFF9, 32'h00000002, 1'b1,
       64'hFFFFFFFD, 64'hFFFFFFFF, 1'b0, 1'b0, 1'b0);

    // random operands against the reference model
    for (int i = 0; i < 1000; i++) begin
      bit w, s, ev, edz, hs;
      int n, kind;
      logic [63:0] dvd, b, m1, m2, uq, eq, er;
      longint sq, sb, sr, absb;
      w    = (i >= 600);
      n    = w ? 32 : 16;
      m1   = (64'd1 << n) - 64'd1;
      m2   = (64'd1 << (2*n)) - 64'd1;
      s    = 1'($urandom_range(0, 1));
      hs   = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 3));
      b    = {$urandom, $urandom} & m1;
      if ($urandom_range(0, 49) == 0) b = '0;
      if (kind == 0 || b == 64'd0) begin
        dvd = {$urandom, $urandom} & m2;
      end else if (s) begin
        sb   = longint'(b << (64 - n)) >>> (64 - n);
        absb = (sb < 0) ? -sb : sb;
        case (kind)
          1:       sq = -(longint'(1) << (n - 1));
          2:       sq = (longint'(1) << (n - 1)) - 1;
          default: sq = longint'({$urandom, $urandom} << (64 - n)) >>> (64 - n);
        endcase
        sr = longint'({$urandom, $urandom} % 64'(absb));
        if ((sq < 0) != (sb < 0)) sr = -sr;
        dvd = 64'(sq * sb + sr) & m2;
      end else begin
        case (kind)
          1:       uq = 64'd1 << (n - 1);
          2:       uq = m1;
          default: uq = {$urandom, $urandom} & m1;
        endcase
        dvd = (uq * b + ({$urandom, $urandom} % b)) & m2;
      end
      model(n, dvd, b, s, eq, er, ev, edz);
      op($sformatf("rnd%0d", i), w, dvd, b[31:0], s, eq, er, ev, edz, hs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
